// File: rtl/camera_link_frame_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : camera_link_frame_decoder_if
//  Brief    : Bundle between the channel-link receiver and the frame decoder.
//             The upstream side drives the raw 28-bit word. The decoder returns
//             the framed pixel stream, the line/frame dimensions and the status
//             strobes.
//  Revision : 1.0  initial release
// ============================================================================
interface camera_link_frame_decoder_if #(
  parameter int PIXEL_COUNT_W = 16,
  parameter int LINE_COUNT_W  = 16
);

  // Raw de-serialised word, bit n = TXn
  logic [27:0]              cl_word;
  logic                     cl_word_valid;

  // Framed pixel stream and status
  logic [23:0]              pixel_data;
  logic                     pixel_valid;
  logic                     pixel_sof;
  logic                     pixel_sol;
  logic                     spare;
  logic                     line_end;
  logic [PIXEL_COUNT_W-1:0] line_length;
  logic                     frame_end;
  logic [LINE_COUNT_W-1:0]  frame_height;
  logic                     line_len_err;
  logic                     sync_err;
  logic                     locked;

  // Word source / stream consumer side
  modport master (
    output cl_word, cl_word_valid,
    input  pixel_data, pixel_valid, pixel_sof, pixel_sol, spare,
    input  line_end, line_length, frame_end, frame_height,
    input  line_len_err, sync_err, locked
  );

  // Decoder side
  modport slave (
    input  cl_word, cl_word_valid,
    output pixel_data, pixel_valid, pixel_sof, pixel_sol, spare,
    output line_end, line_length, frame_end, frame_height,
    output line_len_err, sync_err, locked
  );

endinterface
`default_nettype wire

// File: rtl/camera_link_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : camera_link_frame_decoder
//  Brief    : Camera Link Base-configuration frame decoder. The first stage
//             unscrambles the channel-link word into ports A/B/C and the
//             FVAL/LVAL/DVAL/SPARE bits. The second stage tracks frame and
//             line state and emits a framed pixel stream with start markers,
//             line/frame dimensions and error strobes. There are two register
//             stages from the word input to the outputs.
//  Options  : define CL_DVAL_GATE_EN to qualify LINE words with DVAL. When it
//             is undefined, DVAL is ignored.
//  Revision : 1.0  initial release
// ============================================================================
module camera_link_frame_decoder #(
  parameter int PIXEL_COUNT_W  = 16,
  parameter int LINE_COUNT_W   = 16,
  parameter int EXPECTED_WIDTH = 0
) (
  input  logic                      clk_in,
  input  logic                      reset,
  camera_link_frame_decoder_if.slave cl
);

  localparam logic [PIXEL_COUNT_W-1:0] C_EXP_WIDTH = PIXEL_COUNT_W'(EXPECTED_WIDTH);
  localparam bit                       C_CHECK_EN  = (EXPECTED_WIDTH != 0);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2,
    ST_LINE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Stage 1: unscramble and capture
  // --------------------------------------------------------------------------
  logic [7:0] w_port_a;
  logic [7:0] w_port_b;
  logic [7:0] w_port_c;

  assign w_port_a = {cl.cl_word[5],  cl.cl_word[27], cl.cl_word[6],  cl.cl_word[4],
                     cl.cl_word[3],  cl.cl_word[2],  cl.cl_word[1],  cl.cl_word[0]};
  assign w_port_b = {cl.cl_word[11], cl.cl_word[10], cl.cl_word[14], cl.cl_word[13],
                     cl.cl_word[12], cl.cl_word[9],  cl.cl_word[8],  cl.cl_word[7]};
  assign w_port_c = {cl.cl_word[17], cl.cl_word[16], cl.cl_word[22], cl.cl_word[21],
                     cl.cl_word[20], cl.cl_word[19], cl.cl_word[18], cl.cl_word[15]};

  logic       s1_valid_q;
  logic [7:0] s1_a_q;
  logic [7:0] s1_b_q;
  logic [7:0] s1_c_q;
  logic       s1_lval_q;
  logic       s1_fval_q;
  logic       s1_spare_q;

  // Hold the last valid word's fields; s1_valid_q marks a fresh word for stage 2
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_lval_q  <= 1'b0;
      s1_fval_q  <= 1'b0;
      s1_spare_q <= 1'b0;
    end else begin
      s1_valid_q <= cl.cl_word_valid;
      if (cl.cl_word_valid) begin
        s1_a_q     <= w_port_a;
        s1_b_q     <= w_port_b;
        s1_c_q     <= w_port_c;
        s1_lval_q  <= cl.cl_word[24];
        s1_fval_q  <= cl.cl_word[25];
        s1_spare_q <= cl.cl_word[23];
      end
    end
  end

  // A LINE word becomes a pixel when w_pix_gate is high
  logic w_pix_gate;

`ifdef CL_DVAL_GATE_EN
  logic s1_dval_q;

  // Capture DVAL alongside the other fields of the word
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_dval_q <= 1'b0;
    end else if (cl.cl_word_valid) begin
      s1_dval_q <= cl.cl_word[26];
    end
  end

  assign w_pix_gate = s1_dval_q;
`else
  // DVAL does not take part in pixel qualification in this build
  logic w_unused_dval;
  assign w_unused_dval = cl.cl_word[26];
  assign w_pix_gate    = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Stage 2: frame/line tracking and output generation
  // --------------------------------------------------------------------------
  function automatic logic [PIXEL_COUNT_W-1:0] pix_inc(input logic [PIXEL_COUNT_W-1:0] v);
    return (&v) ? v : v + PIXEL_COUNT_W'(1);
  endfunction

  function automatic logic [LINE_COUNT_W-1:0] line_inc(input logic [LINE_COUNT_W-1:0] v);
    return (&v) ? v : v + LINE_COUNT_W'(1);
  endfunction

  state_t                   state_q,        state_d;
  logic [PIXEL_COUNT_W-1:0] pix_cnt_q,      pix_cnt_d;
  logic [LINE_COUNT_W-1:0]  line_cnt_q,     line_cnt_d;
  logic                     sof_pend_q,     sof_pend_d;
  logic                     sol_pend_q,     sol_pend_d;
  logic [23:0]              pixel_data_q,   pixel_data_d;
  logic                     pixel_valid_q,  pixel_valid_d;
  logic                     pixel_sof_q,    pixel_sof_d;
  logic                     pixel_sol_q,    pixel_sol_d;
  logic                     spare_q,        spare_d;
  logic                     line_end_q,     line_end_d;
  logic [PIXEL_COUNT_W-1:0] line_length_q,  line_length_d;
  logic                     frame_end_q,    frame_end_d;
  logic [LINE_COUNT_W-1:0]  frame_height_q, frame_height_d;
  logic                     line_len_err_q, line_len_err_d;
  logic                     sync_err_q,     sync_err_d;
  logic                     locked_q,       locked_d;
  logic                     w_in_line;

  // Next-state decode. Edges are implied by the state plus the current word,
  // because the state already encodes the FVAL/LVAL of the last accepted word.
  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    line_cnt_d     = line_cnt_q;
    sof_pend_d     = sof_pend_q;
    sol_pend_d     = sol_pend_q;
    pixel_data_d   = pixel_data_q;
    pixel_valid_d  = 1'b0;
    pixel_sof_d    = 1'b0;
    pixel_sol_d    = 1'b0;
    spare_d        = spare_q;
    line_end_d     = 1'b0;
    line_length_d  = line_length_q;
    frame_end_d    = 1'b0;
    frame_height_d = frame_height_q;
    line_len_err_d = 1'b0;
    sync_err_d     = 1'b0;
    w_in_line      = 1'b0;

    if (s1_valid_q) begin
      if (s1_lval_q && !s1_fval_q) begin
        // Line active outside a frame: drop the word and keep the state
        sync_err_d = 1'b1;
      end else begin
        case (state_q)
          ST_SYNC: begin
            if (!s1_fval_q) begin
              state_d = ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (s1_fval_q) begin
              line_cnt_d = '0;
              sof_pend_d = 1'b1;
              if (s1_lval_q) begin
                // FVAL and LVAL rising together open the first line directly
                state_d    = ST_LINE;
                pix_cnt_d  = '0;
                sol_pend_d = 1'b1;
                w_in_line  = 1'b1;
              end else begin
                state_d = ST_FRAME;
              end
            end
          end
          ST_FRAME: begin
            if (!s1_fval_q) begin
              state_d        = ST_IDLE;
              frame_end_d    = 1'b1;
              frame_height_d = line_cnt_q;
            end else if (s1_lval_q) begin
              state_d    = ST_LINE;
              pix_cnt_d  = '0;
              sol_pend_d = 1'b1;
              w_in_line  = 1'b1;
            end
          end
          ST_LINE: begin
            if (s1_lval_q) begin
              w_in_line = 1'b1;
            end else begin
              line_end_d     = 1'b1;
              line_length_d  = pix_cnt_q;
              line_len_err_d = C_CHECK_EN && (pix_cnt_q != C_EXP_WIDTH);
              line_cnt_d     = line_inc(line_cnt_q);
              if (!s1_fval_q) begin
                // Frame closes on the same word: height includes this line
                state_d        = ST_IDLE;
                frame_end_d    = 1'b1;
                frame_height_d = line_cnt_d;
              end else begin
                state_d = ST_FRAME;
              end
            end
          end
          default: state_d = ST_SYNC;
        endcase

        // Outputs stay quiet until the decoder has locked
        if (state_d != ST_SYNC) begin
          spare_d = s1_spare_q;
        end
      end
    end

    if (w_in_line && w_pix_gate) begin
      pixel_valid_d = 1'b1;
      pixel_data_d  = {s1_c_q, s1_b_q, s1_a_q};
      pixel_sol_d   = sol_pend_d;
      pixel_sof_d   = sof_pend_d;
      sol_pend_d    = 1'b0;
      sof_pend_d    = 1'b0;
      pix_cnt_d     = pix_inc(pix_cnt_d);
    end

    locked_d = (state_d != ST_SYNC);
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      sof_pend_q     <= 1'b0;
      sol_pend_q     <= 1'b0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_sof_q    <= 1'b0;
      pixel_sol_q    <= 1'b0;
      spare_q        <= 1'b0;
      line_end_q     <= 1'b0;
      line_length_q  <= '0;
      frame_end_q    <= 1'b0;
      frame_height_q <= '0;
      line_len_err_q <= 1'b0;
      sync_err_q     <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      sof_pend_q     <= sof_pend_d;
      sol_pend_q     <= sol_pend_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_sof_q    <= pixel_sof_d;
      pixel_sol_q    <= pixel_sol_d;
      spare_q        <= spare_d;
      line_end_q     <= line_end_d;
      line_length_q  <= line_length_d;
      frame_end_q    <= frame_end_d;
      frame_height_q <= frame_height_d;
      line_len_err_q <= line_len_err_d;
      sync_err_q     <= sync_err_d;
      locked_q       <= locked_d;
    end
  end

  assign cl.pixel_data   = pixel_data_q;
  assign cl.pixel_valid  = pixel_valid_q;
  assign cl.pixel_sof    = pixel_sof_q;
  assign cl.pixel_sol    = pixel_sol_q;
  assign cl.spare        = spare_q;
  assign cl.line_end     = line_end_q;
  assign cl.line_length  = line_length_q;
  assign cl.frame_end    = frame_end_q;
  assign cl.frame_height = frame_height_q;
  assign cl.line_len_err = line_len_err_q;
  assign cl.sync_err     = sync_err_q;
  assign cl.locked       = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_link_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_link_frame_decoder
//  Brief    : Self-checking bench for camera_link_frame_decoder. Frames are
//             built from a line/pixel description. The expected events are
//             derived from that description, and the events observed on the
//             DUT outputs are compared against them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_camera_link_frame_decoder;

  localparam int PCW  = 3;
  localparam int LCW  = 3;
  localparam int EXPW = 4;
  localparam int MAXP = (1 << PCW) - 1;
  localparam int MAXL = (1 << LCW) - 1;
`ifdef CL_DVAL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  camera_link_frame_decoder_if #(.PIXEL_COUNT_W(PCW), .LINE_COUNT_W(LCW)) cl();

  camera_link_frame_decoder #(
    .PIXEL_COUNT_W (PCW),
    .LINE_COUNT_W  (LCW),
    .EXPECTED_WIDTH(EXPW)
  ) dut (
    .clk_in(clk),
    .reset (rst),
    .cl    (cl)
  );

  typedef struct { int cyc; logic [23:0] data; logic v; logic sof; logic sol; } pix_t;
  typedef struct { int cyc; logic [PCW-1:0] len; logic le; logic err; } line_t;
  typedef struct { int cyc; logic [LCW-1:0] h; } frame_t;
  typedef struct { int cyc; logic v; } spare_t;

  pix_t   exp_pix[$],   act_pix[$];
  line_t  exp_line[$],  act_line[$];
  frame_t exp_frame[$], act_frame[$];
  int     exp_sync[$],  act_sync[$];
  spare_t exp_spare[$];
  logic   spare_log [int];

  int n_cmp = 0;
  int n_err = 0;
  int s_cyc = 0;
  int bubbles = 0;      // 0: none, 1: one idle cycle per word, 2: random 0..2
  bit track_spare = 1'b0;

  // Bit position of each port bit on the channel-link word (index = port bit)
  int amap [8] = '{0, 1, 2, 3, 4, 6, 27, 5};
  int bmap [8] = '{7, 8, 9, 12, 13, 14, 10, 11};
  int cmap [8] = '{15, 18, 19, 20, 21, 22, 16, 17};

  function automatic logic [27:0] mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                     input logic l, input logic f, input logic d, input logic s);
    logic [27:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[amap[i]] = a[i];
      w[bmap[i]] = b[i];
      w[cmap[i]] = c[i];
    end
    w[24] = l; w[25] = f; w[26] = d; w[23] = s;
    return w;
  endfunction

  function automatic logic [27:0] blank(input logic l, input logic f);
    return mk(8'($urandom), 8'($urandom), 8'($urandom), l, f, 1'($urandom), 1'($urandom));
  endfunction

  // Observe DUT outputs away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (cl.pixel_valid || cl.pixel_sof || cl.pixel_sol)
        act_pix.push_back(pix_t'{cyc, cl.pixel_data, cl.pixel_valid, cl.pixel_sof, cl.pixel_sol});
      if (cl.line_end || cl.line_len_err)
        act_line.push_back(line_t'{cyc, cl.line_length, cl.line_end, cl.line_len_err});
      if (cl.frame_end)
        act_frame.push_back(frame_t'{cyc, cl.frame_height});
      if (cl.sync_err)
        act_sync.push_back(cyc);
      spare_log[cyc] = cl.spare;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    assert (act === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic drive(input logic [27:0] w, input logic v);
    cl.cl_word       = w;
    cl.cl_word_valid = v;
    s_cyc            = cyc;
    @(posedge clk);
    #1;
    cl.cl_word_valid = 1'b0;
  endtask

  // Send one valid word, optionally preceded by idle cycles carrying garbage
  task automatic put(input logic [27:0] w);
    int nb;
    nb = (bubbles == 1) ? 1 : (bubbles == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < nb; i++) drive(28'($urandom), 1'b0);
    drive(w, 1'b1);
    if (track_spare && !(w[24] && !w[25])) exp_spare.push_back(spare_t'{s_cyc + 2, w[23]});
  endtask

  // One complete frame; expected events follow from the frame description
  task automatic do_frame(input int nl, input int lens[$], input int dpat[$],
                          input bit together, input bit fixed);
    int lines, cnt, lsat, nblank;
    bit ffirst, lfirst, last;
    logic [7:0] a, b, c;
    logic d;
    lines  = 0;
    ffirst = 1'b1;
    last   = 1'b0;
    put(blank(1'b0, 1'b1));
    for (int ln = 0; ln < nl; ln++) begin
      lfirst = 1'b1;
      cnt    = 0;
      for (int p = 0; p < lens[ln]; p++) begin
        a = fixed ? 8'h11 : 8'($urandom);
        b = fixed ? 8'h22 : 8'($urandom);
        c = fixed ? 8'h33 : 8'($urandom);
        if (ln == 0 && p < dpat.size()) d = (dpat[p] != 0);
        else                            d = fixed ? 1'b1 : 1'($urandom);
        put(mk(a, b, c, 1'b1, 1'b1, d, 1'($urandom)));
        if (d || !GATE) begin
          exp_pix.push_back(pix_t'{s_cyc + 2, {c, b, a}, 1'b1, ffirst, lfirst});
          ffirst = 1'b0;
          lfirst = 1'b0;
          cnt++;
        end
      end
      lines++;
      lsat = (cnt > MAXP) ? MAXP : cnt;
      last = together && (ln == nl - 1);
      put(blank(1'b0, !last));
      exp_line.push_back(line_t'{s_cyc + 2, PCW'(lsat), 1'b1, (lsat != EXPW)});
      if (last) begin
        exp_frame.push_back(frame_t'{s_cyc + 2, LCW'((lines > MAXL) ? MAXL : lines)});
      end else begin
        nblank = fixed ? 1 : int'($urandom_range(0, 2));
        for (int k = 0; k < nblank; k++) put(blank(1'b0, 1'b1));
      end
    end
    if (!last) begin
      put(blank(1'b0, 1'b0));
      exp_frame.push_back(frame_t'{s_cyc + 2, LCW'((lines > MAXL) ? MAXL : lines)});
    end
  endtask

  task automatic clear_all();
    exp_pix.delete();   act_pix.delete();
    exp_line.delete();  act_line.delete();
    exp_frame.delete(); act_frame.delete();
    exp_sync.delete();  act_sync.delete();
    exp_spare.delete(); spare_log.delete();
  endtask

  task automatic check_all(input string tag);
    int c;
    repeat (4) drive(28'd0, 1'b0);
    chk({tag, ":pix_count"}, act_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < act_pix.size(); i++) begin
      chk({tag, ":pix_cycle"}, act_pix[i].cyc,  exp_pix[i].cyc);
      chk({tag, ":pix_valid"}, act_pix[i].v,    exp_pix[i].v);
      chk({tag, ":pix_data"},  act_pix[i].data, exp_pix[i].data);
      chk({tag, ":pix_sof"},   act_pix[i].sof,  exp_pix[i].sof);
      chk({tag, ":pix_sol"},   act_pix[i].sol,  exp_pix[i].sol);
    end
    chk({tag, ":line_count"}, act_line.size(), exp_line.size());
    for (int i = 0; i < exp_line.size() && i < act_line.size(); i++) begin
      chk({tag, ":line_cycle"},  act_line[i].cyc, exp_line[i].cyc);
      chk({tag, ":line_end"},    act_line[i].le,  exp_line[i].le);
      chk({tag, ":line_length"}, act_line[i].len, exp_line[i].len);
      chk({tag, ":line_len_err"}, act_line[i].err, exp_line[i].err);
    end
    chk({tag, ":frame_count"}, act_frame.size(), exp_frame.size());
    for (int i = 0; i < exp_frame.size() && i < act_frame.size(); i++) begin
      chk({tag, ":frame_cycle"},  act_frame[i].cyc, exp_frame[i].cyc);
      chk({tag, ":frame_height"}, act_frame[i].h,   exp_frame[i].h);
    end
    chk({tag, ":sync_count"}, act_sync.size(), exp_sync.size());
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++)
      chk({tag, ":sync_cycle"}, act_sync[i], exp_sync[i]);
    foreach (exp_spare[i]) begin
      c = exp_spare[i].cyc;
      chk({tag, ":spare"}, spare_log.exists(c) ? spare_log[c] : 1'bx, exp_spare[i].v);
    end
    clear_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int none[$];
    int lens[$];
    int dpat[$];
    int nl;

    cl.cl_word       = '0;
    cl.cl_word_valid = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_locked",       cl.locked,       0);
    chk("rst_pixel_valid",  cl.pixel_valid,  0);
    chk("rst_pixel_data",   cl.pixel_data,   0);
    chk("rst_line_length",  cl.line_length,  0);
    chk("rst_frame_height", cl.frame_height, 0);
    chk("rst_line_end",     cl.line_end,     0);
    chk("rst_frame_end",    cl.frame_end,    0);
    chk("rst_sync_err",     cl.sync_err,     0);
    chk("rst_spare",        cl.spare,        0);

    // Active FVAL/LVAL before lock: nothing output; FVAL low locks two cycles on
    repeat (3) put(mk(8'h5a, 8'h5a, 8'h5a, 1'b1, 1'b1, 1'b1, 1'b0));
    repeat (2) drive(28'd0, 1'b0);
    @(negedge clk);
    chk("t1_unlocked", cl.locked, 0);
    put(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t1_locked_lat1", cl.locked, 0);
    @(negedge clk);
    chk("t1_locked_lat2", cl.locked, 1);
    track_spare = 1'b1;
    check_all("t1");

    // 3 lines x 4 pixels of fixed data
    lens = '{4, 4, 4};
    do_frame(3, lens, none, 1'b0, 1'b1);
    check_all("t2");
    chk("t2_frame_height_held", cl.frame_height, 3);
    chk("t2_line_length_held",  cl.line_length,  4);

    // Length check: only the 5-pixel line flags
    lens = '{4, 5, 4};
    do_frame(3, lens, none, 1'b0, 1'b1);
    check_all("t3");

    // Valid toggling every cycle through a 4-pixel line
    bubbles = 1;
    lens = '{4};
    do_frame(1, lens, none, 1'b0, 1'b1);
    check_all("t4");
    chk("t4_line_length", cl.line_length, 4);
    bubbles = 0;

    // FVAL and LVAL falling together, then a line outside a frame
    lens = '{3, 5};
    do_frame(2, lens, none, 1'b1, 1'b1);
    put(blank(1'b1, 1'b0));
    exp_sync.push_back(s_cyc + 2);
    check_all("t5");
    chk("t5_frame_height", cl.frame_height, 2);

    // DVAL pattern on a 6-word line
    lens = '{6};
    dpat = '{1, 0, 1, 0, 1, 1};
    do_frame(1, lens, dpat, 1'b0, 1'b1);
    check_all("t6");
    chk("t6_line_length", cl.line_length, GATE ? 4 : 6);

    // Empty frame
    do_frame(0, none, none, 1'b0, 1'b1);
    check_all("t7");

    // Randomized frames with idle gaps, saturating sizes and stray sync words
    bubbles = 2;
    for (int f = 0; f < 14; f++) begin
      nl = $urandom_range(0, 9);
      lens.delete();
      for (int i = 0; i < nl; i++) lens.push_back($urandom_range(1, 9));
      do_frame(nl, lens, none, (nl > 0) && ($urandom_range(0, 1) == 1), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        put(blank(1'b1, 1'b0));
        exp_sync.push_back(s_cyc + 2);
      end
      check_all("rnd");
    end
    bubbles = 0;

    // Reset mid-line discards the frame and requires FVAL low to relock
    put(blank(1'b0, 1'b1));
    repeat (3) put(blank(1'b1, 1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("t8_rst_locked",      cl.locked,      0);
    chk("t8_rst_pixel_valid", cl.pixel_valid, 0);
    chk("t8_rst_line_length", cl.line_length, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_all();
    track_spare = 1'b0;
    put(blank(1'b0, 1'b1));
    repeat (3) put(blank(1'b1, 1'b1));
    repeat (2) drive(28'd0, 1'b0);
    @(negedge clk);
    chk("t8_still_unlocked", cl.locked, 0);
    put(blank(1'b0, 1'b0));
    repeat (2) @(negedge clk);
    chk("t8_relocked", cl.locked, 1);
    track_spare = 1'b1;
    lens = '{2, 3};
    do_frame(2, lens, none, 1'b0, 1'b1);
    check_all("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
